// File: rtl/sim_mon_pkg.sv
// Shared constants, width helpers and line types for the console line monitor.
// SIM_LINE_TS_EN adds a capture timestamp field to line_pkt_t.
package sim_mon_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int MON_LINE_LEN = 64;
  localparam int MON_CH_NUM   = 2;

  function automatic int len_w(input int line_len);
    return $clog2(line_len + 1);
  endfunction

  function automatic int ch_w(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

  typedef logic [MON_LINE_LEN*8-1:0] line_t;

  typedef struct packed {
    logic [ch_w(MON_CH_NUM)-1:0]    ch;
    line_t                          data;
    logic [len_w(MON_LINE_LEN)-1:0] len;
    logic                           ovf;
`ifdef SIM_LINE_TS_EN
    logic [63:0]                    ts;
`endif
  } line_pkt_t;

endpackage

// File: rtl/sim_line_asm.sv
// One channel: packs bytes into a line buffer and parks finished lines in a one-deep hold.
// SIM_LINE_TS_EN also latches the cycle count when a line enters the hold.
module sim_line_asm
  import sim_mon_pkg::*;
#(
  parameter int LINE_LEN = MON_LINE_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  input  logic [7:0]                    data,
  output logic                          ready,
  input  logic                          pop,
`ifdef SIM_LINE_TS_EN
  input  logic [63:0]                   cycle_cnt,
  output logic [63:0]                   pend_ts,
`endif
  output logic                          pend_valid,
  output logic [LINE_LEN*8-1:0]         pend_data,
  output logic [len_w(LINE_LEN)-1:0]    pend_len,
  output logic                          pend_ovf
);

  localparam int LW = len_w(LINE_LEN);
  localparam int IW = ch_w(LINE_LEN);

  logic [LINE_LEN*8-1:0] acc, acc_nxt;
  logic [LW-1:0]         len;
  logic [IW-1:0]         slot;
  logic                  xfer, term, full;

  assign ready = !pend_valid;
  assign xfer  = valid & ready;
  assign term  = (data == ASCII_LF) || (data == ASCII_CR);
  assign full  = (len == LW'(LINE_LEN - 1));

  // First character lands in the most significant byte.
  always_comb begin
    slot    = IW'(LINE_LEN - 1 - int'(len));
    acc_nxt = acc;
    acc_nxt[{slot, 3'b000} +: 8] = data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      len        <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_len   <= '0;
      pend_ovf   <= 1'b0;
`ifdef SIM_LINE_TS_EN
      pend_ts    <= '0;
`endif
    end else begin
      if (pop) pend_valid <= 1'b0;
      if (xfer) begin
        if (term) begin
          // Empty lines (CR LF pairs) are dropped silently.
          if (len != '0) begin
            pend_valid <= 1'b1;
            pend_data  <= acc;
            pend_len   <= len;
            pend_ovf   <= 1'b0;
`ifdef SIM_LINE_TS_EN
            pend_ts    <= cycle_cnt;
`endif
            acc        <= '0;
            len        <= '0;
          end
        end else if (full) begin
          pend_valid <= 1'b1;
          pend_data  <= acc_nxt;
          pend_len   <= LW'(LINE_LEN);
          pend_ovf   <= 1'b1;
`ifdef SIM_LINE_TS_EN
          pend_ts    <= cycle_cnt;
`endif
          acc        <= '0;
          len        <= '0;
        end else begin
          acc <= acc_nxt;
          len <= len + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sim_line_monitor.sv
// Multi-channel console line assembler with round-robin line output and end/timeout supervisor.
// SIM_LINE_TS_EN adds the line_ts output (cycle count when the line was closed).
module sim_line_monitor
  import sim_mon_pkg::*;
#(
  parameter int          CH_NUM      = MON_CH_NUM,
  parameter int          LINE_LEN    = MON_LINE_LEN,
  parameter logic [63:0] TIMEOUT_CYC = 64'd60000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0]            ch_valid,
  input  logic [CH_NUM*8-1:0]          ch_data,
  output logic [CH_NUM-1:0]            ch_ready,
  output logic                         line_valid,
  input  logic                         line_ready,
  output logic [ch_w(CH_NUM)-1:0]      line_ch,
  output logic [LINE_LEN*8-1:0]        line_data,
  output logic [len_w(LINE_LEN)-1:0]   line_len,
  output logic                         line_ovf,
`ifdef SIM_LINE_TS_EN
  output logic [63:0]                  line_ts,
`endif
  input  logic                         end_req,
  output logic                         sim_done,
  output logic                         sim_timeout,
  output logic [63:0]                  cycle_cnt
);

  localparam int CW = ch_w(CH_NUM);
  localparam int LW = len_w(LINE_LEN);

  logic [CH_NUM-1:0]                 pend_valid, pop, pend_ovf;
  logic [CH_NUM-1:0][LINE_LEN*8-1:0] pend_data;
  logic [CH_NUM-1:0][LW-1:0]         pend_len;
`ifdef SIM_LINE_TS_EN
  logic [CH_NUM-1:0][63:0]           pend_ts;
`endif
  logic [CW-1:0] ptr, grant;
  logic          found, load;
  int            c;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    sim_line_asm #(.LINE_LEN(LINE_LEN)) u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (ch_valid[i]),
      .data       (ch_data[8*i +: 8]),
      .ready      (ch_ready[i]),
      .pop        (pop[i]),
`ifdef SIM_LINE_TS_EN
      .cycle_cnt  (cycle_cnt),
      .pend_ts    (pend_ts[i]),
`endif
      .pend_valid (pend_valid[i]),
      .pend_data  (pend_data[i]),
      .pend_len   (pend_len[i]),
      .pend_ovf   (pend_ovf[i])
    );
  end

  // Round-robin search starting at ptr.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      c = (int'(ptr) + k) % CH_NUM;
      if (!found && pend_valid[c]) begin
        grant = CW'(c);
        found = 1'b1;
      end
    end
  end

  assign load = found & (!line_valid | line_ready);

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      line_valid <= 1'b0;
      line_ch    <= '0;
      line_data  <= '0;
      line_len   <= '0;
      line_ovf   <= 1'b0;
`ifdef SIM_LINE_TS_EN
      line_ts    <= '0;
`endif
    end else if (load) begin
      ptr        <= (int'(grant) == CH_NUM - 1) ? '0 : grant + 1'b1;
      line_valid <= 1'b1;
      line_ch    <= grant;
      line_data  <= pend_data[grant];
      line_len   <= pend_len[grant];
      line_ovf   <= pend_ovf[grant];
`ifdef SIM_LINE_TS_EN
      line_ts    <= pend_ts[grant];
`endif
    end else if (line_ready) begin
      line_valid <= 1'b0;
    end
  end

  // Supervisor: both flags use the pre-edge sim_done, so they can set together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      sim_done    <= 1'b0;
      sim_timeout <= 1'b0;
    end else begin
      if (!sim_done && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 64'd1;
      if (end_req) sim_done <= 1'b1;
      if (!sim_done && (cycle_cnt == TIMEOUT_CYC - 64'd1)) sim_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_line_monitor.sv
// Bench for sim_line_monitor: per-channel byte model feeds a scoreboard checked at line output.
// Covers table vectors, overflow, arbitration stall, reset mid-line, timeout and end-of-sim.
module tb_sim_line_monitor;
  import sim_mon_pkg::*;

  localparam int CH = 2;
  localparam int LL = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     ch_valid = '0;
  logic [CH*8-1:0]   ch_data = '0;
  logic [CH-1:0]     ch_ready;
  logic              line_valid;
  logic              line_ready = 1'b0;
  logic              line_ch;
  logic [LL*8-1:0]   line_data;
  logic [6:0]        line_len;
  logic              line_ovf;
`ifdef SIM_LINE_TS_EN
  logic [63:0]       line_ts;
`endif
  logic              end_req = 1'b0;
  logic              sim_done, sim_timeout;
  logic [63:0]       cycle_cnt;

  sim_line_monitor #(.CH_NUM(CH), .LINE_LEN(LL), .TIMEOUT_CYC(64'd100)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .line_valid(line_valid), .line_ready(line_ready), .line_ch(line_ch), .line_data(line_data),
    .line_len(line_len), .line_ovf(line_ovf),
`ifdef SIM_LINE_TS_EN
    .line_ts(line_ts),
`endif
    .end_req(end_req), .sim_done(sim_done), .sim_timeout(sim_timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  line_pkt_t exp_q[CH][$];
  byte       acc[CH][$];
  int        lines_seen = 0, last_len = 0, cyc = 0;
  int        del_ch[$], del_t[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic chk_line(string name, logic [LL*8-1:0] act, logic [LL*8-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Model: close a line from the byte accumulator into the channel's scoreboard queue.
  task automatic push_line(int ch, logic ovf);
    line_pkt_t p;
    p      = '0;
    p.ch   = 1'(ch);
    p.len  = 7'(acc[ch].size());
    p.ovf  = ovf;
    for (int i = 0; i < acc[ch].size(); i++) p.data[(LL-1-i)*8 +: 8] = acc[ch][i];
    exp_q[ch].push_back(p);
    acc[ch].delete();
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(int ch, byte b);
    int n;
    n = 0;
    ch_valid[ch] = 1'b1;
    ch_data[ch*8 +: 8] = b;
    while (!ch_ready[ch] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL ch_ready_wait ch%0d: got stalled %0d cycles, want accept", ch, n);
    end else begin
      @(negedge clk);
      if (b == 8'h0A || b == 8'h0D) begin
        if (acc[ch].size() > 0) push_line(ch, 1'b0);
      end else begin
        acc[ch].push_back(b);
        if (acc[ch].size() == LL) push_line(ch, 1'b1);
      end
    end
    ch_valid[ch] = 1'b0;
  endtask

  task automatic send_str(int ch, string s);
    for (int i = 0; i < s.len(); i++) send_byte(ch, s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_valid = '0; end_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < CH; k++) begin exp_q[k].delete(); acc[k].delete(); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  line_pkt_t e;
  bit        hold_v = 0;
  logic      h_ch, h_ovf;
  logic [LL*8-1:0] h_data;
  logic [6:0] h_len;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && hold_v) begin
      chk("hold_valid", line_valid, 1'b1);
      chk("hold_ch", line_ch, h_ch);
      chk("hold_len", line_len, h_len);
      chk("hold_ovf", line_ovf, h_ovf);
      chk_line("hold_data", line_data, h_data);
    end
    if (rst_n && line_valid && line_ready) begin
      if (exp_q[line_ch].size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_line: got ch%0d len %0d, want no line", line_ch, line_len);
      end else begin
        e = exp_q[line_ch].pop_front();
        chk("line_len", line_len, e.len);
        chk("line_ovf", line_ovf, e.ovf);
        chk_line("line_data", line_data, e.data);
      end
      lines_seen++;
      last_len = int'(line_len);
      del_ch.push_back(int'(line_ch));
      del_t.push_back(cyc);
    end
    hold_v = rst_n && line_valid && !line_ready;
    h_ch = line_ch; h_len = line_len; h_ovf = line_ovf; h_data = line_data;
  end

  typedef struct {
    int    ch;
    string txt;
    int    n_lines;
    int    last_len;
  } vec_t;

  vec_t vt[5];
  int   l0, n;

  initial begin
    vt[0] = '{0, "Hi\n", 1, 2};
    vt[1] = '{0, "\r\n\r\n", 0, 0};
    vt[2] = '{1, "abc\r\n", 1, 3};
    vt[3] = '{0, "\nX\r", 1, 1};
    vt[4] = '{1, "hello world\n", 1, 11};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_line_len", line_len, 7'd0);
    chk_line("rst_line_data", line_data, '0);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_sim_done", sim_done, 1'b0);
    chk("rst_sim_timeout", sim_timeout, 1'b0);
    rst_n = 1'b1;

    // Timeout at count 100
    n = 0;
    while (cycle_cnt != 64'd99 && n < 300) begin @(negedge clk); n++; end
    chk("to_reach_99", cycle_cnt, 64'd99);
    chk("to_before", sim_timeout, 1'b0);
    @(negedge clk);
    chk("to_cnt", cycle_cnt, 64'd100);
    chk("to_set", sim_timeout, 1'b1);

    // "Hi\n" latency
    do_reset();
    line_ready = 1'b1;
    send_str(0, "Hi");
    send_byte(0, 8'h0A);
    chk("hi_not_yet", line_valid, 1'b0);
    @(negedge clk);
    chk("hi_valid", line_valid, 1'b1);
    chk("hi_ch", line_ch, 1'b0);
    chk("hi_len", line_len, 7'd2);
    chk("hi_top", line_data[LL*8-1 -: 16], 16'h4869);
    repeat (3) @(negedge clk);

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      l0 = lines_seen;
      send_str(vt[v].ch, vt[v].txt);
      repeat (5) @(negedge clk);
      chk("vec_lines", lines_seen - l0, vt[v].n_lines);
      if (vt[v].n_lines > 0) chk("vec_len", last_len, vt[v].last_len);
      chk("vec_ready", ch_ready, 2'b11);
    end

    // 65 'A' then LF on ch1
    l0 = lines_seen;
    for (int i = 0; i < 65; i++) send_byte(1, 8'h41);
    send_byte(1, 8'h0A);
    repeat (5) @(negedge clk);
    chk("ovf_lines", lines_seen - l0, 2);
    chk("ovf_last_len", last_len, 1);

    // Simultaneous completion, output stalled
    do_reset();
    line_ready = 1'b0;
    fork
      send_str(0, "ab\n");
      send_str(1, "ab\n");
    join
    send_str(0, "c\n");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", line_valid, 1'b1);
      chk("stall_ch", line_ch, 1'b0);
      chk("stall_ready", ch_ready, 2'b00);
    end
    del_ch.delete(); del_t.delete();
    line_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("rr_count", del_ch.size(), 3);
    if (del_ch.size() == 3) begin
      chk("rr_first", del_ch[0], 0);
      chk("rr_second", del_ch[1], 1);
      chk("rr_third", del_ch[2], 0);
      chk("rr_b2b", del_t[1] - del_t[0], 1);
    end

    // Reset mid-line
    line_ready = 1'b0;
    send_str(1, "q\n");
    send_str(0, "abc");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", line_valid, 1'b0);
    chk("mid_rst_len", line_len, 7'd0);
    chk_line("mid_rst_data", line_data, '0);
    chk("mid_rst_cnt", cycle_cnt, 64'd0);
    for (int k = 0; k < CH; k++) begin exp_q[k].delete(); acc[k].delete(); end
    @(negedge clk);
    rst_n = 1'b1;
    line_ready = 1'b1;
    l0 = lines_seen;
    repeat (5) @(negedge clk);
    chk("mid_no_stale", lines_seen - l0, 0);
    send_str(0, "Z\n");
    repeat (5) @(negedge clk);
    chk("mid_z_lines", lines_seen - l0, 1);
    chk("mid_z_len", last_len, 1);

    // End request at count 50
    do_reset();
    n = 0;
    while (cycle_cnt != 64'd50 && n < 200) begin @(negedge clk); n++; end
    chk("end_reach_50", cycle_cnt, 64'd50);
    end_req = 1'b1;
    @(negedge clk);
    end_req = 1'b0;
    chk("end_done", sim_done, 1'b1);
    chk("end_cnt", cycle_cnt, 64'd51);
    repeat (100) @(negedge clk);
    chk("end_frozen", cycle_cnt, 64'd51);
    chk("end_no_timeout", sim_timeout, 1'b0);
    chk("end_sticky", sim_done, 1'b1);

    for (int k = 0; k < CH; k++) chk("sb_drained", exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
